// File: rtl/lfsr_range_sampler.sv
// lfsr_range_sampler: drives an external XNOR LFSR, turns its words into
// uniform symbols 0..RANGE-1 by rejection sampling and queues them in a
// small FIFO behind a valid/ready handshake.
module lfsr_range_sampler #(
    parameter int NUM_BITS   = 4,
    parameter int RANGE      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_TRIES  = 16,
    localparam int VAL_W     = $clog2(RANGE),
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic [NUM_BITS-1:0] i_Seed,
    output logic                o_LFSR_Enable,
    output logic                o_Seed_DV,
    output logic [NUM_BITS-1:0] o_Seed_Data,
    input  logic [NUM_BITS-1:0] i_LFSR_Data,
    output logic [VAL_W-1:0]    o_Value,
    output logic                o_Valid,
    input  logic                i_Ready,
    output logic [CNT_W-1:0]    o_Count,
    output logic                o_Busy,
    output logic                o_Fallback
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_STEP, S_CHECK, S_WAIT} state_t;

    state_t              state, state_next;
    logic [NUM_BITS-1:0] seed_reg;
    logic [VAL_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [TRY_W-1:0]    tries, tries_next;
    logic [VAL_W-1:0]    pend_val, cand_val, push_val, m;
    logic                pend_fb, push_fb;
    logic                fallback;
    logic                valid, full, pop, push, can_push;
    logic                accept, forced, push_due;
    logic                unused_lfsr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Only the low VAL_W bits of the LFSR word form a candidate.
    assign unused_lfsr = ^i_LFSR_Data;
    assign m           = i_LFSR_Data[VAL_W-1:0];

    assign valid    = (count != '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    // A restart discards the queue, so a pop in that cycle does not count.
    assign pop      = valid & i_Ready & ~i_Start;
    assign can_push = ~full | pop;

    // Widen by one bit so a power-of-two RANGE accepts every candidate.
    assign accept   = ({1'b0, m} < (VAL_W + 1)'(RANGE));
    assign forced   = ~accept & (tries == TRY_W'(MAX_TRIES - 1));
    assign push_due = accept | forced;
    assign cand_val = accept ? m : '0;

    // Next-state, push decision and rejection counter update.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        push_val   = cand_val;
        push_fb    = forced;
        tries_next = tries;
        case (state)
            S_IDLE:  state_next = S_IDLE;
            S_SEED:  state_next = S_STEP;
            S_STEP:  state_next = S_CHECK;
            S_CHECK: begin
                if (push_due) tries_next = '0;
                else          tries_next = tries + 1'b1;
                if (push_due && !can_push) begin
                    state_next = S_WAIT;
                end else begin
                    state_next = S_STEP;
                    push       = push_due;
                end
            end
            S_WAIT: begin
                push_val = pend_val;
                push_fb  = pend_fb;
                if (can_push) begin
                    push       = 1'b1;
                    state_next = S_STEP;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (i_Start) begin
            state_next = S_SEED;
            push       = 1'b0;
            tries_next = '0;
        end
    end

    // Control registers: state, seed, tries, sticky fallback, pending slot.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= S_IDLE;
            seed_reg <= '0;
            tries    <= '0;
            fallback <= 1'b0;
            pend_val <= '0;
            pend_fb  <= 1'b0;
        end else begin
            state <= state_next;
            tries <= tries_next;
            if (i_Start) begin
                // All-ones would lock the XNOR LFSR, so load zero instead.
                seed_reg <= (&i_Seed) ? '0 : i_Seed;
                fallback <= 1'b0;
            end else if (push && push_fb) begin
                fallback <= 1'b1;
            end
            if (state == S_CHECK && push_due && !can_push && !i_Start) begin
                pend_val <= cand_val;
                pend_fb  <= forced;
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge i_Clk) begin
        if (push) mem[wr_ptr] <= push_val;
    end

    // FIFO pointers and occupancy, flushed on reset and on restart.
    always_ff @(posedge i_Clk) begin
        if (i_Rst || i_Start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign o_LFSR_Enable = (state == S_SEED) || (state == S_STEP);
    assign o_Seed_DV     = (state == S_SEED);
    assign o_Seed_Data   = seed_reg;
    assign o_Value       = valid ? mem[rd_ptr] : '0;
    assign o_Valid       = valid;
    assign o_Count       = count;
    assign o_Busy        = (state != S_IDLE);
    assign o_Fallback    = fallback;

endmodule

// File: doc/lfsr_range_sampler.md
Name: lfsr_range_sampler

Overview:
- Sits directly downstream of the parameterised XNOR LFSR.
- Drives the LFSR's enable and seed inputs, and samples its data output.
- Converts raw LFSR words into values uniformly distributed in 0..RANGE-1 by rejection sampling, and buffers them in a small FIFO with a valid/ready output handshake.
- Game logic pops one random symbol per round (e.g. the next colour or lane) without knowing LFSR timing.

Parameters:
- NUM_BITS, 4, LFSR width; must match the connected LFSR (3..32).
- RANGE, 3, number of output symbols; 2 <= RANGE <= 2^NUM_BITS.
- FIFO_DEPTH, 4, buffered values (>= 1).
- MAX_TRIES, 16, consecutive rejections before a fallback value is forced (>= 1).
- Derived, not overridable: VAL_W = clog2(RANGE); CNT_W = clog2(FIFO_DEPTH+1).

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  synchronous, active-high reset
- i_Start  in  1  one-cycle pulse: (re)seed and start/restart filling
- i_Seed  in  NUM_BITS  seed captured on i_Start
- o_LFSR_Enable  out  1  to LFSR i_Enable
- o_Seed_DV  out  1  to LFSR i_Seed_DV
- o_Seed_Data  out  NUM_BITS  to LFSR i_Seed_Data
- i_LFSR_Data  in  NUM_BITS  from LFSR o_LFSR_Data
- o_Value  out  VAL_W  FIFO head
- o_Valid  out  1  FIFO non-empty
- i_Ready  in  1  consumer accepts o_Value
- o_Count  out  CNT_W  FIFO occupancy
- o_Busy  out  1  high in any state other than IDLE
- o_Fallback  out  1  sticky; a forced value was pushed since the last i_Start

Behaviour:
- Reset (i_Rst=1 at a clock edge, wins over everything):
  - state=IDLE, FIFO emptied, try counter=0.
  - All outputs 0, including o_Seed_Data, o_Valid, o_Count and o_Fallback.
- The seed register is captured on i_Start.
  - If i_Seed is all ones (the XNOR lock-up state), 0 is substituted.
  - o_Seed_Data always equals the seed register.
- States and transitions:
  - IDLE: enable=0. On i_Start -> SEED.
  - SEED: o_Seed_DV=1, o_LFSR_Enable=1 for exactly one cycle, so the LFSR loads the seed. -> STEP.
  - STEP: o_LFSR_Enable=1 for one cycle (the LFSR advances). -> CHECK.
  - CHECK: enable=0. i_LFSR_Data now holds the advanced word. m = i_LFSR_Data[VAL_W-1:0].
    - m < RANGE: accept. Push m; tries=0.
    - Otherwise reject, and tries increments. When tries reaches MAX_TRIES: push 0, set o_Fallback, tries=0.
    - If a push is due and the FIFO is full with no pop this cycle: hold the candidate in a one-entry pending register -> WAIT.
    - Otherwise -> STEP.
  - WAIT: enable=0. The pending value is pushed in the first cycle in which count<FIFO_DEPTH or a pop occurs. -> STEP.
- Throughput: at most one value per 2 cycles. The LFSR is never advanced while WAIT holds, so no word is lost.
- FIFO:
  - Pop occurs when o_Valid & i_Ready.
  - Push and pop in the same cycle are legal, including when full; count is unchanged.
  - o_Value is the registered head. The first push into an empty FIFO is visible with o_Valid=1 on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- i_Start while busy, in any state:
  - Flush the FIFO and the pending register; clear tries and o_Fallback.
  - Recapture the seed -> SEED.
  - A pop in the same cycle is ignored.
- i_Ready while o_Valid=0 has no effect.

Test Plan:
- Startup: real LFSR instance, NUM_BITS=4, RANGE=3, DEPTH=4, MAX_TRIES=16, seed 0, i_Ready=1. LFSR words 0001, 0011, 0111, 1110, 1101, 1011, 0110, 1100 -> accepted sequence 1, 2, 1, 2, 0; o_Fallback stays 0.
- Fallback: same configuration with MAX_TRIES=2 -> words 0001, 0011 (reject), 0111 (reject, forced) give output 1, 0, 2, 1; o_Fallback=1 from the cycle of the forced push.
- Back-pressure: i_Ready=0 -> o_Count saturates at 4; the block enters WAIT with o_LFSR_Enable=0. Raising i_Ready pops 1, 2, 1, 2 then 0 with no skipped value; o_Count never exceeds 4.
- Lock-up guard: i_Seed=4'b1111 -> o_Seed_Data=0 and output identical to the seed-0 case.
- Restart and reset: i_Start mid-fill with o_Count=3 -> next cycle o_Count=0 and o_Fallback=0, then the sequence restarts from the new seed. i_Rst during CHECK -> next cycle IDLE, all outputs 0, o_LFSR_Enable=0.
